// File: rtl/register_file_pkg.sv
// Shared GPU definitions: core phase encoding, register write-source
// encoding and the register-file address map.
`timescale 1ns/1ps
package register_file_pkg;

    // Core pipeline phase as broadcast by the scheduler
    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    // Source of the value written back into rd
    typedef enum logic [1:0] {
        MUX_ARITHMETIC = 2'b00,
        MUX_MEMORY     = 2'b01,
        MUX_CONSTANT   = 2'b10,
        MUX_RESERVED   = 2'b11
    } reg_input_mux_t;

    // Register map: R0..R12 general purpose, R13..R15 read-only
    localparam int         NUM_REGS      = 16;
    localparam int         GP_REGS       = 13;
    localparam logic [3:0] BLOCK_ID_REG  = 4'd13;
    localparam logic [3:0] THREADS_REG   = 4'd14;
    localparam logic [3:0] THREAD_ID_REG = 4'd15;

    // Only the general-purpose registers accept writeback
    function automatic logic is_writable(input logic [3:0] addr);
        return addr < BLOCK_ID_REG;
    endfunction

endpackage

// File: rtl/register_file_write_mux.sv
// REG_WriteMux: picks the writeback value for rd from the ALU, the LSU or
// the decoded immediate. The reserved select reports no valid data.
`timescale 1ns/1ps
module register_file_write_mux
    import register_file_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       mux,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] lsu_out,
    input  logic [WIDTH-1:0] immediate,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    // Select the write source; reserved encoding yields no write
    always_comb begin
        data  = '0;
        valid = 1'b0;
        case (reg_input_mux_t'(mux))
            MUX_ARITHMETIC: begin
                data  = alu_out;
                valid = 1'b1;
            end
            MUX_MEMORY: begin
                data  = lsu_out;
                valid = 1'b1;
            end
            MUX_CONSTANT: begin
                data  = immediate;
                valid = 1'b1;
            end
            default: begin
                data  = '0;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/register_file.sv
// Per-thread register file: 13 general-purpose registers plus read-only
// block id, block dimension and thread id. Operands are captured into
// rs/rt during REQUEST and held for the rest of the instruction; results
// are committed during UPDATE.
`timescale 1ns/1ps
module register_file
    import register_file_pkg::*;
#(
    parameter int WIDTH             = 8,
    parameter int THREAD_ID         = 0,
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] block_id,
    input  logic [2:0]       core_state,
    input  logic [3:0]       decoded_rd_address,
    input  logic [3:0]       decoded_rs_address,
    input  logic [3:0]       decoded_rt_address,
    input  logic             decoded_reg_write_enable,
    input  logic [1:0]       decoded_reg_input_mux,
    input  logic [WIDTH-1:0] decoded_immediate,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] lsu_out,
    output logic [WIDTH-1:0] rs,
    output logic [WIDTH-1:0] rt
);

    logic [WIDTH-1:0]   gp_regs   [GP_REGS];
    logic [WIDTH-1:0]   block_reg;
    logic [WIDTH-1:0]   read_view [NUM_REGS];
    logic [WIDTH-1:0]   write_data;
    logic               write_valid;
    logic               write_strobe;
    logic [GP_REGS-1:0] write_hit;
    logic               request_phase;

    register_file_write_mux #(
        .WIDTH (WIDTH)
    ) u_write_mux (
        .mux       (decoded_reg_input_mux),
        .alu_out   (alu_out),
        .lsu_out   (lsu_out),
        .immediate (decoded_immediate),
        .data      (write_data),
        .valid     (write_valid)
    );

    assign request_phase = enable && (core_state_t'(core_state) == CORE_REQUEST);

    // Writes to R13..R15 fail is_writable and are dropped here
    assign write_strobe = enable
                       && (core_state_t'(core_state) == CORE_UPDATE)
                       && decoded_reg_write_enable
                       && is_writable(decoded_rd_address)
                       && write_valid;

    // Per-register write decode and read-side view of the general registers
    generate
        for (genvar gi = 0; gi < GP_REGS; gi++) begin : g_gp
            assign write_hit[gi] = write_strobe && (decoded_rd_address == 4'(gi));
            assign read_view[gi] = gp_regs[gi];
        end
    endgenerate

    // Special registers: R13 tracks block_id, R14/R15 are fixed constants
    assign read_view[BLOCK_ID_REG]  = block_reg;
    assign read_view[THREADS_REG]   = WIDTH'(THREADS_PER_BLOCK);
    assign read_view[THREAD_ID_REG] = WIDTH'(THREAD_ID);

    // General-purpose register writeback during UPDATE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < GP_REGS; i++) begin
                gp_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < GP_REGS; i++) begin
                if (write_hit[i]) begin
                    gp_regs[i] <= write_data;
                end
            end
        end
    end

    // R13 follows block_id on every enabled cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            block_reg <= '0;
        end else if (enable) begin
            block_reg <= block_id;
        end
    end

    // Operand capture in REQUEST; held through WAIT/EXECUTE and beyond
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs <= '0;
            rt <= '0;
        end else if (request_phase) begin
            rs <= read_view[decoded_rs_address];
            rt <= read_view[decoded_rt_address];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios with literal expectations
// followed by randomized traffic, all checked against a behavioural model.
`timescale 1ns/1ps
module tb_register_file;

    localparam int WIDTH = 8;
    localparam int TID   = 2;
    localparam int TPB   = 4;

    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_REQUEST = 3'b011;
    localparam logic [2:0] ST_UPDATE  = 3'b110;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] block_id;
    logic [2:0]       core_state;
    logic [3:0]       rd_a;
    logic [3:0]       rs_a;
    logic [3:0]       rt_a;
    logic             we;
    logic [1:0]       mux;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] lsu;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;

    int checks = 0;
    int errors = 0;

    // Behavioural model: the architectural register contents and operands
    logic [WIDTH-1:0] m_regs [16];
    logic [WIDTH-1:0] m_rs;
    logic [WIDTH-1:0] m_rt;
    logic [WIDTH-1:0] rd_val_s;
    logic [WIDTH-1:0] rd_val_t;

    always #5 clk = ~clk;

    register_file #(
        .WIDTH             (WIDTH),
        .THREAD_ID         (TID),
        .THREADS_PER_BLOCK (TPB)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .block_id                 (block_id),
        .core_state               (core_state),
        .decoded_rd_address       (rd_a),
        .decoded_rs_address       (rs_a),
        .decoded_rt_address       (rt_a),
        .decoded_reg_write_enable (we),
        .decoded_reg_input_mux    (mux),
        .decoded_immediate        (imm),
        .alu_out                  (alu),
        .lsu_out                  (lsu),
        .rs                       (rs),
        .rt                       (rt)
    );

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_regs[14] = 8'(TPB);
        m_regs[15] = 8'(TID);
        m_rs = '0;
        m_rt = '0;
    endtask

    // Reset is asynchronous: the model clears the moment it falls
    always @(negedge reset) model_reset();

    // Advance the model on each edge, then compare the DUT just after it
    always @(posedge clk) begin
        if (reset === 1'b1) begin
            rd_val_s = m_regs[rs_a];
            rd_val_t = m_regs[rt_a];
            if (enable === 1'b1) begin
                if (core_state == ST_REQUEST) begin
                    m_rs = rd_val_s;
                    m_rt = rd_val_t;
                end
                if (core_state == ST_UPDATE && we && rd_a < 4'd13 && mux != 2'd3)
                    m_regs[rd_a] = (mux == 2'd0) ? alu : (mux == 2'd1) ? lsu : imm;
                m_regs[13] = block_id;
            end
            #1;
            if (reset === 1'b1) begin
                chk("model_rs", rs, m_rs);
                chk("model_rt", rt, m_rt);
            end
        end
    end

    task automatic cyc(input logic [2:0] st);
        core_state = st;
        @(negedge clk);
    endtask

    task automatic request(input logic [3:0] a, input logic [3:0] b);
        rs_a = a;
        rt_a = b;
        cyc(ST_REQUEST);
        $display("REQUEST rs_a=%0d rt_a=%0d en=%0b -> rs=%02h rt=%02h", a, b, enable, rs, rt);
    endtask

    task automatic update(input logic [3:0] rd, input logic w, input logic [1:0] m,
                          input logic [7:0] a, input logic [7:0] l, input logic [7:0] i);
        rd_a = rd;
        we   = w;
        mux  = m;
        alu  = a;
        lsu  = l;
        imm  = i;
        cyc(ST_UPDATE);
        $display("UPDATE rd=%0d we=%0b mux=%0d alu=%02h lsu=%02h imm=%02h en=%0b", rd, w, m, a, l, i, enable);
        we = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; block_id = '0; core_state = ST_IDLE;
        rd_a = '0; rs_a = '0; rt_a = '0; we = 1'b0; mux = '0;
        imm = '0; alu = '0; lsu = '0;
        model_reset();
        #2;
        chk("reset_rs", rs, 8'h00);
        chk("reset_rt", rt, 8'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Constant registers and reset contents
        request(4'd14, 4'd15);
        chk("read_r14", rs, 8'h04);
        chk("read_r15", rt, 8'h02);
        request(4'd0, 4'd12);
        chk("read_r0", rs, 8'h00);
        chk("read_r12", rt, 8'h00);

        // Each write source into R3
        update(4'd3, 1'b1, 2'd0, 8'h5A, 8'hE1, 8'h7E);
        request(4'd3, 4'd0);
        chk("wb_alu", rs, 8'h5A);
        update(4'd3, 1'b1, 2'd1, 8'h10, 8'hC3, 8'h20);
        request(4'd3, 4'd0);
        chk("wb_lsu", rs, 8'hC3);
        update(4'd3, 1'b1, 2'd2, 8'h40, 8'h50, 8'h11);
        request(4'd3, 4'd0);
        chk("wb_imm", rs, 8'h11);

        // Dropped writes: read-only target, write disabled, reserved mux
        update(4'd15, 1'b1, 2'd2, 8'h00, 8'h00, 8'hFF);
        request(4'd15, 4'd3);
        chk("ro_r15", rs, 8'h02);
        update(4'd5, 1'b0, 2'd0, 8'h77, 8'h77, 8'h77);
        update(4'd4, 1'b1, 2'd3, 8'h66, 8'h66, 8'h66);
        request(4'd5, 4'd4);
        chk("no_we_r5", rs, 8'h00);
        chk("mux11_r4", rt, 8'h00);

        // Block id tracking and hold while disabled
        block_id = 8'd7;
        cyc(ST_IDLE);
        request(4'd13, 4'd0);
        chk("r13_7", rs, 8'h07);
        enable = 1'b0;
        block_id = 8'd9;
        cyc(ST_IDLE);
        enable = 1'b1;
        request(4'd13, 4'd0);
        chk("r13_held", rs, 8'h07);
        request(4'd13, 4'd0);
        chk("r13_9", rs, 8'h09);

        // Disabled UPDATE and REQUEST
        enable = 1'b0;
        update(4'd1, 1'b1, 2'd0, 8'hAA, 8'h00, 8'h00);
        enable = 1'b1;
        request(4'd1, 4'd13);
        chk("dis_upd_r1", rs, 8'h00);
        request(4'd3, 4'd13);
        enable = 1'b0;
        request(4'd0, 4'd14);
        chk("dis_req_rs", rs, 8'h11);
        chk("dis_req_rt", rt, 8'h09);
        enable = 1'b1;

        // Reset pulse in the middle of an UPDATE
        rd_a = 4'd2; we = 1'b1; mux = 2'd0; alu = 8'h33;
        core_state = ST_UPDATE;
        reset = 1'b0;
        #2;
        chk("async_rs", rs, 8'h00);
        chk("async_rt", rt, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        we = 1'b0;
        request(4'd2, 4'd3);
        chk("post_rst_r2", rs, 8'h00);
        chk("post_rst_r3", rt, 8'h00);
        request(4'd14, 4'd15);
        chk("post_rst_r14", rs, 8'h04);
        chk("post_rst_r15", rt, 8'h02);

        // Randomized traffic checked by the model
        for (int n = 0; n < 500; n++) begin
            enable     = ($urandom_range(0, 7) != 0);
            reset      = ($urandom_range(0, 59) != 0);
            core_state = 3'($urandom_range(0, 7));
            rd_a       = 4'($urandom_range(0, 15));
            rs_a       = 4'($urandom_range(0, 15));
            rt_a       = 4'($urandom_range(0, 15));
            we         = 1'($urandom_range(0, 1));
            mux        = 2'($urandom_range(0, 3));
            imm        = 8'($urandom);
            alu        = 8'($urandom);
            lsu        = 8'($urandom);
            if ($urandom_range(0, 9) == 0) block_id = 8'($urandom);
            @(negedge clk);
            $display("RAND %0d rst=%0b en=%0b st=%0d rd=%0d rs_a=%0d rt_a=%0d -> rs=%02h rt=%02h",
                     n, reset, enable, core_state, rd_a, rs_a, rt_a, rs, rt);
        end

        reset = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 8, data width of every register and data port.
REQ-002 Parameter THREAD_ID, default 0, index of this thread within its block; a constant readable in R15.
REQ-003 Parameter THREADS_PER_BLOCK, default 4, block dimension; a constant readable in R14.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-low reset.
REQ-006 Port enable, input, 1, thread active; when low the block holds all state.
REQ-007 Port block_id, input, WIDTH, current block index; shown in R13.
REQ-008 Port core_state, input, 3, core phase (IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111).
REQ-009 Ports decoded_rd_address, decoded_rs_address, decoded_rt_address, input, 4 each, register indices.
REQ-010 Port decoded_reg_write_enable, input, 1, instruction writes rd.
REQ-011 Port decoded_reg_input_mux, input, 2, write source select (00 ARITHMETIC, 01 MEMORY, 10 CONSTANT, 11 reserved).
REQ-012 Port decoded_immediate, input, WIDTH, constant operand.
REQ-013 Port alu_out, input, WIDTH, ALU result.
REQ-014 Port lsu_out, input, WIDTH, load/store unit read data.
REQ-015 Port rs, output, WIDTH, registered first operand to the ALU and LSU.
REQ-016 Port rt, output, WIDTH, registered second operand to the ALU and LSU.

Function
REQ-017 The block SHALL hold 16 registers of WIDTH bits: R0-R12 general purpose, R13 block_id, R14 THREADS_PER_BLOCK, R15 THREAD_ID.
REQ-018 When enable is high on any cycle, R13 SHALL load block_id, so R13 reflects block_id one cycle after it changes.
REQ-019 When enable is high and core_state == REQUEST, rs SHALL load R[decoded_rs_address] and rt SHALL load R[decoded_rt_address], both 1-cycle latency.
REQ-020 rs and rt SHALL hold their values in every other state, so they are stable through WAIT and EXECUTE.
REQ-021 Writeback SHALL occur only when all of these hold on the edge: enable high, core_state == UPDATE, decoded_reg_write_enable high, decoded_rd_address < 13, and mux != 11.
REQ-022 Write data SHALL be alu_out for mux 00, lsu_out for mux 01, and decoded_immediate for mux 10; mux 11 SHALL write nothing.
REQ-023 A write to R13-R15 SHALL be silently dropped; those registers are read-only.
REQ-024 A read in REQUEST SHALL return the value committed by the previous instruction's UPDATE; no same-cycle bypass is required, because REQUEST and UPDATE never coincide.
REQ-025 When enable is low, no register, rs, or rt SHALL change, whatever core_state is.
REQ-026 Values outside the 0..2^WIDTH-1 range do not arise; all data SHALL pass unmodified with no extension or truncation.

Reset
REQ-027 When reset is low, the block SHALL asynchronously clear rs, rt, R0-R12 and R13 to 0 and set R14=THREADS_PER_BLOCK and R15=THREAD_ID.
REQ-028 Reset asserted mid-instruction (any core_state) SHALL abort any pending writeback; after release, the first REQUEST reads the reset values.

Structure
REQ-029 The core_state encoding and the reg_input_mux encoding (ARITHMETIC, MEMORY, CONSTANT) SHALL live in the shared GPU package, used with the decoder and ALU.
REQ-030 The write-source selection SHALL be one combinational sub-module, REG_WriteMux (inputs: mux select, alu_out, lsu_out, immediate; outputs: data and valid).

Verification
REQ-031 Reset with THREAD_ID=2 and THREADS_PER_BLOCK=4, then REQUEST with rs=14, rt=15 -> rs=4, rt=2; REQUEST with rs=0, rt=12 -> rs=0, rt=0.
REQ-032 UPDATE with rd=3, mux=00, alu_out=0x5A, then REQUEST with rs=3 -> rs=0x5A; repeat with mux=01, lsu_out=0xC3 -> 0xC3; repeat with mux=10, immediate=0x11 -> 0x11.
REQ-033 UPDATE with rd=15, mux=10, immediate=0xFF -> a later read of R15 returns THREAD_ID; with rd=5 and decoded_reg_write_enable=0 -> R5 is unchanged.
REQ-034 block_id=7 with enable high, then REQUEST with rs=13 -> rs=7; change block_id to 9 while enable is low -> R13 stays 7 until enable returns high.
REQ-035 enable low during UPDATE with rd=1, alu_out=0xAA -> R1 unchanged; enable low during REQUEST -> rs and rt hold their previous values.
REQ-036 Assert reset low for one cycle during UPDATE with rd=2, alu_out=0x33 -> R2=0 and rs=rt=0, and the reset response appears before the next clock edge.
